// File: rtl/dadda_mul_arbiter.sv
// dadda_mul_arbiter: round-robin sharing of one 4x4 Dadda multiplier with a registered tagged response
module dadda_mul_4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] product,
  output logic       overflow
);
  logic [3:0] p [4];
  logic s1, c1, s2, c2, s3, c3, s4, c4, s5, c5, s6, c6;
  logic [7:0] row_x, row_y;
  always_comb
    for (int i = 0; i < 4; i++) p[i] = {4{a[i]}} & b;
  // reduce column heights 4 -> 3 -> 2, then one carry-propagate add
  assign {c1, s1} = p[0][3] + p[1][2];
  assign {c2, s2} = p[1][3] + p[2][2];
  assign {c3, s3} = p[0][2] + p[1][1];
  assign {c4, s4} = s1 + p[2][1] + p[3][0];
  assign {c5, s5} = s2 + p[3][1] + c1;
  assign {c6, s6} = p[2][3] + p[3][2] + c2;
  assign row_x = {1'b0, p[3][3], s6, s5, s4, s3, p[0][1], p[0][0]};
  assign row_y = {1'b0, c6, c5, c4, c3, p[2][0], p[1][0], 1'b0};
  assign product = row_x + row_y;
  assign overflow = |product[7:4];
endmodule

module dadda_mul_arbiter #(
  parameter int WIDTH   = 4,
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16,
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [2*WIDTH-1:0]       rsp_product,
  output logic                     rsp_overflow,
  output logic [CNT_W-1:0]         op_count
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state;
  logic [IDW-1:0] rr_ptr, gnt_idx;
  logic found, can_accept, accept, mul_ovf;
  logic [WIDTH-1:0] mul_a, mul_b;
  logic [2*WIDTH-1:0] mul_p;
  // scan from the highest offset down so the nearest requester after rr_ptr wins
  always_comb begin
    gnt_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req_valid[(int'(rr_ptr) + k) % NUM_REQ]) gnt_idx = IDW'((int'(rr_ptr) + k) % NUM_REQ);
  end
  assign found = |req_valid;
  assign can_accept = (state == EMPTY) || rsp_ready;
  assign req_ready = (found && can_accept) ? NUM_REQ'(1) << gnt_idx : '0;
  assign accept = |req_ready;
  assign mul_a = found ? req_a[int'(gnt_idx)*WIDTH +: WIDTH] : '0;
  assign mul_b = found ? req_b[int'(gnt_idx)*WIDTH +: WIDTH] : '0;
  dadda_mul_4x4 u_mul (.a(mul_a), .b(mul_b), .product(mul_p), .overflow(mul_ovf));
  assign rsp_valid = (state == FULL);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      rsp_id <= '0;
      rsp_product <= '0;
      rsp_overflow <= 1'b0;
      op_count <= '0;
      rr_ptr <= '0;
    end else if (accept) begin
      state <= FULL;
      rsp_id <= gnt_idx;
      rsp_product <= mul_p;
      rsp_overflow <= mul_ovf;
      op_count <= op_count + CNT_W'(1);
      rr_ptr <= (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
    end else if (rsp_ready) begin
      state <= EMPTY;
    end
  end
endmodule

// File: tb/tb_dadda_mul_arbiter.sv
// tb_dadda_mul_arbiter: random and directed checks against a transaction-level reference model
module tb_dadda_mul_arbiter;
  localparam int N = 4, W = 4, C = 4, IDW = 2;
  logic clk = 0, rst;
  logic [N-1:0] req_valid, req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic rsp_valid, rsp_ready, rsp_overflow;
  logic [IDW-1:0] rsp_id;
  logic [2*W-1:0] rsp_product;
  logic [C-1:0] op_count;
  int errs = 0, checks = 0;
  bit m_valid;
  int m_id, m_prod, m_ovf, m_cnt, m_ptr, last_grant;
  logic [2*W-1:0] held;

  dadda_mul_arbiter #(.WIDTH(W), .NUM_REQ(N), .CNT_W(C)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_product(rsp_product), .rsp_overflow(rsp_overflow),
    .op_count(op_count));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_id = 0; m_prod = 0; m_ovf = 0; m_cnt = 0; m_ptr = 0;
  endtask

  // one clock: compare outputs on the falling edge, then advance the model across the rising edge
  task automatic cycle();
    int g, a, b;
    bit can;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    g = -1;
    can = !m_valid || rsp_ready;
    for (int k = 0; k < N; k++)
      if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    exp_rdy = (g >= 0 && can) ? N'(1) << g : '0;
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    chk("rsp_id", 32'(rsp_id), m_id);
    chk("rsp_product", 32'(rsp_product), m_prod);
    chk("rsp_overflow", 32'(rsp_overflow), m_ovf);
    chk("op_count", 32'(op_count), m_cnt);
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    last_grant = (exp_rdy != 0) ? g : -1;
    if (rst) model_reset();
    else if (exp_rdy != 0) begin
      a = int'(req_a[g*W +: W]);
      b = int'(req_b[g*W +: W]);
      m_valid = 1; m_id = g; m_prod = a * b; m_ovf = (a * b >= 2**W) ? 1 : 0;
      m_cnt = (m_cnt + 1) % (2**C); m_ptr = (g + 1) % N;
    end else if (rsp_ready) m_valid = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input int a, input int b);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
  endtask

  initial begin
    rst = 1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    // single requester 2: 3*5
    req_valid = 4'b0100; set_lane(2, 3, 5); rsp_ready = 1;
    cycle();
    chk("s1_grant", last_grant, 2);
    req_valid = '0;
    chk("s1_product", 32'(rsp_product), 15);
    chk("s1_id", 32'(rsp_id), 2);
    chk("s1_count", 32'(op_count), 1);
    cycle();
    // reset, then all valid: strict rotation with no bubbles
    rst = 1; cycle(); rst = 0;
    req_valid = 4'b1111;
    for (int i = 0; i < N; i++) set_lane(i, $urandom_range(15), $urandom_range(15));
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("rr_order", last_grant, i % N);
      chk("no_bubble", 32'(rsp_valid), 1);
    end
    // corner operands from requester 1
    req_valid = 4'b0010;
    set_lane(1, 15, 15); cycle(); chk("corner_225", 32'(rsp_product), 225);
    set_lane(1, 0, 9);   cycle(); chk("corner_0", 32'(rsp_product), 0);
    set_lane(1, 15, 1);  cycle(); chk("corner_15", 32'(rsp_product), 15);
    // backpressure: hold 3 cycles, then back-to-back accept
    req_valid = 4'b1111;
    cycle();
    rsp_ready = 0;
    held = rsp_product;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_hold", 32'(rsp_product), 32'(held));
      chk("bp_ready_zero", 32'(req_ready), 0);
    end
    rsp_ready = 1;
    cycle();
    chk("bp_b2b_grant", 32'(last_grant >= 0), 1);
    chk("bp_still_full", 32'(rsp_valid), 1);
    // reset right after an accept while stalled
    cycle();
    rst = 1; rsp_ready = 0; cycle(); rst = 0;
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_count", 32'(op_count), 0);
    rsp_ready = 1;
    cycle();
    chk("rst_first_grant", last_grant, 0);
    // counter wrap with CNT_W=4: 16 accepts -> 0, 17 -> 1
    rst = 1; cycle(); rst = 0;
    for (int i = 1; i <= 17; i++) begin
      cycle();
      if (i == 16) chk("wrap_16", 32'(op_count), 0);
      if (i == 17) chk("wrap_17", 32'(op_count), 1);
    end
    // random traffic; requesters hold requests until the model says they were accepted
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] || last_grant == i) begin
          req_valid[i] = ($urandom_range(3) != 0);
          set_lane(i, $urandom_range(15), $urandom_range(15));
        end
      rsp_ready = ($urandom_range(9) < 7);
      rst = ($urandom_range(63) == 0);
      cycle();
      if (rst) req_valid = '0;
      rst = 0;
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/dadda_mul_arbiter.md
Name: dadda_mul_arbiter

Overview:
- Shares one 4x4 Dadda multiplier among NUM_REQ requesters using round-robin arbitration.
- Each requester has a valid/ready request channel. All requesters share one tagged response channel.
- The multiplier is instantiated internally through the team's multiplier interface (mul_side). It is purely combinational.
- This block adds the arbitration, a one-entry result register with backpressure, and an operation counter.
- It is the front end that lets several processing lanes time-share one (exact or approximate) multiplier instance.

Parameters:
- WIDTH, 4, operand width; must match the instantiated Dadda multiplier.
- NUM_REQ, 4, number of requesters, 2..8.
- CNT_W, 16, width of the accepted-operation counter.
- Localparam IDW = $clog2(NUM_REQ).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  request valid, one bit per requester.
- req_ready  output  NUM_REQ  request accepted this cycle, one-hot or zero.
- req_a  input  NUM_REQ*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  operand B; same packing as req_a.
- rsp_valid  output  1  result register holds a valid product.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  IDW  index of the requester that owns the product.
- rsp_product  output  2*WIDTH  unsigned product A*B.
- rsp_overflow  output  1  overflow flag from the multiplier, registered.
- op_count  output  CNT_W  number of accepted requests since reset; wraps.

Behaviour:
- Reset (rst=1 at a clock edge): rsp_valid=0, rsp_id=0, rsp_product=0, rsp_overflow=0, op_count=0, rr_ptr=0, stage state=EMPTY. Reset overrides all other activity in the same cycle.
- Output-stage FSM: two states, EMPTY and FULL.
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY when rsp_ready=1 and there is no accept.
  - FULL -> FULL when rsp_ready=0, or when rsp_ready=1 with an accept (back-to-back).
  - rsp_valid = (state == FULL).
- can_accept = (state == EMPTY) || rsp_ready.
- Arbitration (combinational):
  - grant = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
  - req_ready[i] = grant[i] && can_accept.
  - No requester is granted when no req_valid is set.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
- Accept = any req_ready bit high.
- On accept of index g:
  - Operands of g drive the multiplier.
  - rsp_product, rsp_overflow and rsp_id <= g are registered at the next edge.
  - rr_ptr <= (g+1) mod NUM_REQ.
  - op_count <= op_count+1, wrapping from 2^CNT_W-1 to 0.
- With no accept, rr_ptr and op_count hold.
- Latency: a product is visible on rsp_* exactly 1 cycle after the accept edge.
- Throughput: one operation per cycle while rsp_ready=1.
- Backpressure: while FULL and rsp_ready=0:
  - rsp_valid, rsp_id, rsp_product and rsp_overflow hold stable.
  - All req_ready bits are 0.
  - Requesters must hold their request (valid stays 1, operands stable) until accepted.
- Requests left pending do not starve. Round-robin bounds the wait to NUM_REQ-1 grants to other requesters.
- Multiplier inputs are driven with zero when there is no grant, to avoid spurious toggling.
- Reset mid-operation: any in-flight product is discarded with no response. Requests pending at reset are not remembered.
- Operands are unsigned. Product width is 2*WIDTH; upper bits are zero-extended if the multiplier output is narrower.

Test Plan:
- After reset only req_valid[2]=1 with a=3, b=5 -> req_ready=0100 in the same cycle; next cycle rsp_valid=1, rsp_id=2, rsp_product=15, op_count=1.
- All four requesters valid continuously, rsp_ready=1 -> grants in cycle order 0,1,2,3,0,1. The rsp_id sequence matches, one response per cycle with no bubbles.
- Corner operands 15*15, 0*9 and 15*1 from requester 1 -> rsp_product=225, then 0, then 15.
- Result held with rsp_ready=0 for 3 cycles while req_valid=1111 -> rsp_* unchanged and req_ready=0000 throughout.
  - Raising rsp_ready gives a same-cycle accept of the next requester (back-to-back), and the state stays FULL.
- Reset asserted one cycle after an accept, with rsp_ready=0 -> next cycle rsp_valid=0, op_count=0, rr_ptr=0, and the first grant after reset goes to index 0 when all requesters are valid.
- CNT_W=4 with 17 accepted operations -> op_count reads 0 after the 16th accept and 1 after the 17th.
